// File: rtl/magic_button_ctrl_pkg.sv
// Shared types and sizing helpers for the magic-button front end.
// Optional long-press reboot is enabled by defining MAGIC_LONGPRESS_REBOOT_EN.
package magic_button_ctrl_pkg;

  typedef enum logic [1:0] {MB_IDLE, MB_ARMED, MB_HELD, MB_LONG} magic_btn_state_t;

  // clk28 cycles per ms tick, never below one
  function automatic int ms_div(input int clk_hz);
    return (clk_hz / 1000 < 1) ? 1 : clk_hz / 1000;
  endfunction

  // Width of a counter that must hold values 0..n-1, at least one bit
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/magic_button_ctrl_debounce.sv
// Two-flop synchroniser, free-running ms prescaler and ms-based debouncer for
// an active-low panel button. Reusable for any front-panel key.
module magic_button_ctrl_debounce
  import magic_button_ctrl_pkg::*;
#(
  parameter int CLK_HZ      = 28000000,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic rst_n,
  input  logic clk28,
  input  logic in_n,
  output logic ms_tick,
  output logic stable
);

  localparam int            DIV      = ms_div(CLK_HZ);
  localparam int            PW       = cnt_w(DIV);
  localparam int            DW       = cnt_w(DEBOUNCE_MS);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_MS - 1);

  logic [PW-1:0] pre_q;
  logic [1:0]    sync_q;
  logic [DW-1:0] db_cnt_q;
  logic          pressed_raw;
  logic          mismatch;

  assign ms_tick     = (pre_q == PRE_LAST);
  assign pressed_raw = ~sync_q[1];
  assign mismatch    = pressed_raw ^ stable;

  // Free-running ms prescaler; first interval after reset may be short
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n)       pre_q <= '0;
    else if (ms_tick) pre_q <= '0;
    else              pre_q <= pre_q + PW'(1);
  end

  // Synchroniser idles at 1 so a held button re-debounces after reset
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], in_n};
  end

  // Accept a change only after DEBOUNCE_MS consecutive mismatched ticks
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_q <= '0;
      stable   <= 1'b0;
    end else if (!mismatch) begin
      db_cnt_q <= '0;
    end else if (ms_tick) begin
      if (db_cnt_q == DB_LAST) begin
        stable   <= pressed_raw;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + DW'(1);
      end
    end
  end

endmodule

// File: rtl/magic_button_ctrl.sv
// Magic (NMI) request front end: merges the debounced panel button with the
// keyboard hotkey and holds magic_button until the controller has seen it on
// an n_int falling-edge cycle. Define MAGIC_LONGPRESS_REBOOT_EN to enable
// the long-press reboot_req path (hold_ms counter and LONG state).
module magic_button_ctrl
  import magic_button_ctrl_pkg::*;
#(
  parameter int CLK_HZ      = 28000000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 2000
) (
  input  logic rst_n,
  input  logic clk28,
  input  logic btn_n,
  input  logic key_magic,
  input  logic n_int,
  input  logic n_int_next,
  output logic magic_button,
  output logic reboot_req,
  output logic btn_stable
);

  magic_btn_state_t state_q, state_d;
  logic             ms_tick;
  logic             press;
  logic             int_edge;
  logic             long_hit;

  magic_button_ctrl_debounce #(
    .CLK_HZ      (CLK_HZ),
    .DEBOUNCE_MS (DEBOUNCE_MS)
  ) u_debounce (
    .rst_n   (rst_n),
    .clk28   (clk28),
    .in_n    (btn_n),
    .ms_tick (ms_tick),
    .stable  (btn_stable)
  );

  assign press    = btn_stable | key_magic;
  assign int_edge = n_int & ~n_int_next;

`ifdef MAGIC_LONGPRESS_REBOOT_EN
  localparam int            HW       = $clog2(LONG_MS + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_MS);

  logic [HW-1:0] hold_ms_q;

  // Button-only hold time in ms, saturating; the hotkey never counts
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n)
      hold_ms_q <= '0;
    else if (state_q == MB_IDLE)
      hold_ms_q <= '0;
    else if ((state_q == MB_ARMED || state_q == MB_HELD) && ms_tick && btn_stable &&
             hold_ms_q != HOLD_MAX)
      hold_ms_q <= hold_ms_q + HW'(1);
  end

  assign long_hit = (hold_ms_q == HOLD_MAX);

  // Registered reboot level, stable until release
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) reboot_req <= 1'b0;
    else        reboot_req <= (state_d == MB_LONG);
  end
`else
  logic unused_ms_tick;

  assign unused_ms_tick = ms_tick;
  assign long_hit       = 1'b0;
  assign reboot_req     = 1'b0;
`endif

  // Request sequencing: arm on press, deliver on int edge, rearm only after release
  always_comb begin
    state_d = state_q;
    case (state_q)
      MB_IDLE:  if (press)     state_d = MB_ARMED;
      MB_ARMED: if (int_edge)  state_d = MB_HELD;
      MB_HELD:  if (!press)    state_d = MB_IDLE;
                else if (long_hit) state_d = MB_LONG;
      MB_LONG:  if (!press)    state_d = MB_IDLE;
      default:                 state_d = MB_IDLE;
    endcase
  end

  // State register with the magic request registered alongside it
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= MB_IDLE;
      magic_button <= 1'b0;
    end else begin
      state_q      <= state_d;
      magic_button <= (state_d == MB_ARMED);
    end
  end

endmodule

// File: tb/tb_magic_button_ctrl.sv
// Scoreboard bench for magic_button_ctrl: CLK_HZ=1000 (ms tick every cycle),
// DEBOUNCE_MS=4, LONG_MS=20. Expected outputs per step come from closed-form
// timing of each scenario and are queued as the stimulus is driven.
module tb_magic_button_ctrl;

  logic clk28 = 1'b0;
  logic rst_n = 1'b0;
  logic btn_n = 1'b1;
  logic key_magic = 1'b0;
  logic n_int = 1'b1;
  logic n_int_next = 1'b1;
  logic magic_button, reboot_req, btn_stable;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    int   k;
    logic st;
    logic mb;
    logic rb;
  } exp_t;

  exp_t sb[$];

  always #5 clk28 = ~clk28;

  magic_button_ctrl #(
    .CLK_HZ      (1000),
    .DEBOUNCE_MS (4),
    .LONG_MS     (20)
  ) dut (
    .rst_n        (rst_n),
    .clk28        (clk28),
    .btn_n        (btn_n),
    .key_magic    (key_magic),
    .n_int        (n_int),
    .n_int_next   (n_int_next),
    .magic_button (magic_button),
    .reboot_req   (reboot_req),
    .btn_stable   (btn_stable)
  );

  task automatic chk(input string tag, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b", tag, got, exp);
    end
  endtask

  // Step k: inputs applied before clock edge k, outputs observed just after it.
  // Button low on steps P..R-1 (P=0: none); int edge on steps E and E2;
  // hotkey high on step K only.
  function automatic exp_t expect_at(input int k, input int P, input int R,
                                     input int E, input int K, input int E2);
    exp_t x;
    int a, l, d;
    x.k  = k;
    x.st = 1'b0;
    x.mb = 1'b0;
    x.rb = 1'b0;
    if (P > 0 && R - P >= 4) begin
      // 2 sync edges + 4 debounce ticks, then one more edge to arm
      a    = P + 6;
      x.st = (k >= P + 5) && (k < R + 5);
      x.mb = (k >= a) && (k < E);
      l    = (a + 21 > E + 1) ? a + 21 : E + 1;
`ifdef MAGIC_LONGPRESS_REBOOT_EN
      if (a + 19 <= R + 4) x.rb = (k >= l) && (k < R + 6);
`endif
    end else if (K > 0) begin
      d    = (E > K) ? E : E2;
      x.mb = (k >= K) && (k < d);
    end
    return x;
  endfunction

  task automatic run_scn(input string name, input int P, input int R, input int E,
                         input int K, input int E2, input int N);
    exp_t x;
    for (int k = 1; k <= N; k++) begin
      btn_n      = !(P > 0 && k >= P && k < R);
      key_magic  = (k == K);
      n_int_next = !((E > 0 && k == E) || (E2 > 0 && k == E2));
      n_int      = !((E > 0 && k == E + 1) || (E2 > 0 && k == E2 + 1));
      sb.push_back(expect_at(k, P, R, E, K, E2));
      @(posedge clk28);
      #1;
      x = sb.pop_front();
      chk($sformatf("%s[%0d].btn_stable", name, x.k), btn_stable, x.st);
      chk($sformatf("%s[%0d].magic_button", name, x.k), magic_button, x.mb);
      chk($sformatf("%s[%0d].reboot_req", name, x.k), reboot_req, x.rb);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk28);
    #1;
    chk("reset.btn_stable", btn_stable, 1'b0);
    chk("reset.magic_button", magic_button, 1'b0);
    chk("reset.reboot_req", reboot_req, 1'b0);
    rst_n = 1'b1;

    //      name        P  R     E   K  E2  N
    run_scn("glitch",   1, 4,    0,  0, 0,  15);
    run_scn("basic",    1, 41,   12, 0, 0,  55);
    run_scn("tap",      0, 0,    52, 2, 0,  60);
    run_scn("tap_edge", 0, 0,    5,  5, 30, 40);
    run_scn("long",     1, 61,   10, 0, 0,  75);
    run_scn("simul",    1, 40,   27, 0, 0,  55);
    run_scn("late_int", 1, 50,   35, 0, 0,  65);
    run_scn("min_deb",  1, 5,    20, 0, 0,  30);

    // Reset while HELD with the button still down
    run_scn("pre_rst",  1, 1000, 10, 0, 0,  15);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.btn_stable", btn_stable, 1'b0);
    chk("midrst.magic_button", magic_button, 1'b0);
    chk("midrst.reboot_req", reboot_req, 1'b0);
    repeat (2) @(posedge clk28);
    #1;
    rst_n = 1'b1;
    run_scn("post_rst", 1, 30,   20, 0, 0,  45);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
